fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter sequencer and instruction-memory request controller for the front end of the processor. It owns the PC, issues one-at-a-time read requests to instruction memory, buffers each returned instruction in a single-entry output register for decode, and applies stall, branch redirect and end-of-program halt. It replaces free-running PC increment with an explicit request/acknowledge handshake on both sides.

## Interface
- ADDR_W, 9, PC / instruction-memory address width
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC value after reset
- LAST_PC, 13, address of final instruction; fetching it ends the program
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- stall_en  in  1  1 = do not launch a new memory request
- redirect_valid  in  1  one-cycle pulse: load PC from redirect_addr, flush
- redirect_addr  in  ADDR_W  new PC
- imem_req  out  1  read request outstanding
- imem_addr  out  ADDR_W  request address, stable while imem_req=1
- imem_ack  in  1  read data valid this cycle, completes request
- imem_rdata  in  INSTR_W  read data, sampled when imem_ack=1
- out_valid  out  1  instruction buffered for decode
- out_ready  in  1  decode accepts this cycle
- out_instr  out  INSTR_W  buffered instruction
- out_pc  out  ADDR_W  address of out_instr
- halted  out  1  program end reached, no further requests
- pc  out  ADDR_W  next address to fetch

## Operation
- States: IDLE, BUSY, DISCARD, HALT; reset state IDLE. imem_req=1 exactly in BUSY and DISCARD (Moore, registered).
- IDLE: redirect_valid -> pc<=redirect_addr, stay. Else if !stall_en and (!out_valid or out_ready) -> imem_addr<=pc, go BUSY. Else stay.
- BUSY: redirect_valid has priority. redirect with imem_ack -> data dropped, pc<=redirect_addr, go IDLE. redirect without ack -> pc<=redirect_addr, go DISCARD. No redirect, imem_ack -> out_instr<=imem_rdata, out_pc<=imem_addr, out_valid<=1; if imem_addr==LAST_PC go HALT, else pc<=pc+1 (mod 2^ADDR_W, wraps to 0), go IDLE. No ack -> stay; stall_en ignored for an outstanding request.
- DISCARD: imem_addr unchanged. imem_ack -> data dropped, go IDLE. redirect_valid -> pc updated again, stays DISCARD (or IDLE if ack same cycle).
- HALT: halted=1, no requests. redirect_valid -> pc<=redirect_addr, halted<=0, go IDLE. Buffered last instruction still drains normally.
- Output buffer: out_valid clears on out_valid&out_ready. Load and consume same cycle -> out_valid stays 1 with new data. redirect_valid clears out_valid next cycle regardless of out_ready or state; a same-cycle load is suppressed by redirect (BUSY rules above).
- stall_en never modifies pc, out_valid or an outstanding request.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
- Reset mid-request: outstanding request abandoned immediately; memory must tolerate req dropping without ack.
- First imem_req=1 on the cycle after reset release (if stall_en=0).
- imem_ack may arrive in the first BUSY cycle or any later cycle; ack outside BUSY/DISCARD is ignored.
- Ack at cycle n -> out_valid=1 at n+1; next request (no stall, buffer drains) at n+2. Peak throughput one instruction per 2 cycles with zero-wait memory.
- Redirect at cycle n -> pc and flush visible at n+1; first request for the new target no earlier than n+2.

## Structure
- Package fetch_pkg: state enum (IDLE, BUSY, DISCARD, HALT), default ADDR_W/INSTR_W constants.
- Sub-module fetch_buf: single-entry output register with valid/ready, load, flush; instantiated once.
- PC, imem_addr and FSM stay in fetch_ctrl.

## Test plan
- Reset, stall_en=0, zero-wait memory, out_ready=1 -> requests at 0..13 in order, out_pc 0..13 each with matching data, halted=1 after address 13, no request afterwards.
- Memory ack delayed 3 cycles at address 4 -> imem_req/imem_addr=4 held for 4 cycles, single buffer load, pc becomes 5.
- out_ready=0 with out_valid=1 -> no new request issued; raise out_ready -> request on following cycle, no instruction lost or duplicated.
- Redirect to 9 while request for 2 outstanding (ack 2 cycles later) -> DISCARD, data for 2 never reaches out_valid, next request address 9; repeat with ack in redirect cycle -> same result without DISCARD.
- stall_en=1 for 5 cycles in IDLE -> imem_req stays 0, pc unchanged; stall raised during BUSY -> request completes normally.
- In HALT, redirect to 0 -> halted=0, fetch restarts at 0; async rst asserted mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DISCARD,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry output register between instruction memory and decode.
module fetch_buf #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] load_instr_i,
    input  logic [ADDR_W-1:0]  load_pc_i,
    input  logic               flush_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Flush wins over everything; a load may coincide with the entry being consumed.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = load_instr_i;
            pc_d    = load_pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer and one-at-a-time instruction-memory request controller.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INSTR_W  = INSTR_W_DEF,
    parameter int RESET_PC = 0,
    parameter int LAST_PC  = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc
);

    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] LastPc  = ADDR_W'(LAST_PC);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              bufLoad;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        bufLoad = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                end else if (!stall_en && (!out_valid || out_ready)) begin
                    addr_d  = pc_q;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A redirect drops whatever the memory returns for the old path.
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    bufLoad = 1'b1;
                    if (addr_q == LastPc) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= ResetPc;
            addr_q  <= ResetPc;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    fetch_buf #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_i       (bufLoad),
        .load_instr_i (imem_rdata),
        .load_pc_i    (addr_q),
        .flush_i      (redirect_valid),
        .ready_i      (out_ready),
        .valid_o      (out_valid),
        .instr_o      (out_instr),
        .pc_o         (out_pc)
    );

    assign imem_req  = (state_q == BUSY) || (state_q == DISCARD);
    assign imem_addr = addr_q;
    assign halted    = (state_q == HALT);
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with a zero-latency memory word function.
module tb_fetch_ctrl;

    localparam int ADDR_W  = 9;
    localparam int INSTR_W = 32;
    localparam int NVEC    = 45;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stallEn = 1'b1;
    logic               redirectValid = 1'b0;
    logic [ADDR_W-1:0]  redirectAddr = '0;
    logic               imemReq;
    logic [ADDR_W-1:0]  imemAddr;
    logic               imemAck = 1'b0;
    logic [INSTR_W-1:0] imemRdata;
    logic               outValid;
    logic               outReady = 1'b1;
    logic [INSTR_W-1:0] outInstr;
    logic [ADDR_W-1:0]  outPc;
    logic               halted;
    logic [ADDR_W-1:0]  pc;

    int totalChecks = 0;
    int badChecks   = 0;

    typedef struct {
        logic              stall;
        logic              redir;
        logic [ADDR_W-1:0] raddr;
        logic              ack;
        logic              ready;
        logic              expReq;
        logic [ADDR_W-1:0] expAddr;
        logic              expValid;
        logic [ADDR_W-1:0] expOutPc;
        logic              expHalted;
        logic [ADDR_W-1:0] expPc;
    } vec_t;

    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 7'b0, a};
    endfunction

    assign imemRdata = memWord(imemAddr);

    fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (0),
        .LAST_PC  (13)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_en       (stallEn),
        .redirect_valid (redirectValid),
        .redirect_addr  (redirectAddr),
        .imem_req       (imemReq),
        .imem_addr      (imemAddr),
        .imem_ack       (imemAck),
        .imem_rdata     (imemRdata),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_instr      (outInstr),
        .out_pc         (outPc),
        .halted         (halted),
        .pc             (pc)
    );

    function automatic vec_t mkVec(input int s, input int r, input int ra, input int a,
                                   input int rdy, input int q, input int ad, input int ov,
                                   input int op, input int h, input int p);
        vec_t v;
        v.stall     = 1'(s);
        v.redir     = 1'(r);
        v.raddr     = ADDR_W'(ra);
        v.ack       = 1'(a);
        v.ready     = 1'(rdy);
        v.expReq    = 1'(q);
        v.expAddr   = ADDR_W'(ad);
        v.expValid  = 1'(ov);
        v.expOutPc  = ADDR_W'(op);
        v.expHalted = 1'(h);
        v.expPc     = ADDR_W'(p);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        stallEn       = v.stall;
        redirectValid = v.redir;
        redirectAddr  = v.raddr;
        imemAck       = v.ack;
        outReady      = v.ready;
    endtask

    task automatic checkVector(input int i);
        vec_t v;
        v = vecs[i];
        checkOutput($sformatf("v%0d.req", i), 32'(imemReq), 32'(v.expReq));
        checkOutput($sformatf("v%0d.addr", i), 32'(imemAddr), 32'(v.expAddr));
        checkOutput($sformatf("v%0d.valid", i), 32'(outValid), 32'(v.expValid));
        checkOutput($sformatf("v%0d.outPc", i), 32'(outPc), 32'(v.expOutPc));
        checkOutput($sformatf("v%0d.halted", i), 32'(halted), 32'(v.expHalted));
        checkOutput($sformatf("v%0d.pc", i), 32'(pc), 32'(v.expPc));
        if (v.expValid) begin
            checkOutput($sformatf("v%0d.instr", i), outInstr, memWord(v.expOutPc));
        end
    endtask

    initial begin
        int expReq;
        int expOut;
        int lateReqs;

        //                 stall redir raddr ack rdy | req addr ov opc h  pc
        vecs[0]  = mkVec(0, 0,  0, 0, 1,  0,  0, 0,  0, 0,  0);
        vecs[1]  = mkVec(0, 0,  0, 1, 1,  1,  0, 0,  0, 0,  0);
        vecs[2]  = mkVec(0, 0,  0, 0, 1,  0,  0, 1,  0, 0,  1);
        vecs[3]  = mkVec(0, 0,  0, 1, 1,  1,  1, 0,  0, 0,  1);
        vecs[4]  = mkVec(0, 0,  0, 0, 1,  0,  1, 1,  1, 0,  2);
        vecs[5]  = mkVec(0, 0,  0, 1, 1,  1,  2, 0,  1, 0,  2);
        vecs[6]  = mkVec(0, 0,  0, 0, 1,  0,  2, 1,  2, 0,  3);
        vecs[7]  = mkVec(0, 0,  0, 1, 1,  1,  3, 0,  2, 0,  3);
        vecs[8]  = mkVec(0, 0,  0, 0, 1,  0,  3, 1,  3, 0,  4);
        // Address 4: ack held off three cycles, stall raised while outstanding
        vecs[9]  = mkVec(1, 0,  0, 0, 1,  1,  4, 0,  3, 0,  4);
        vecs[10] = mkVec(1, 0,  0, 0, 1,  1,  4, 0,  3, 0,  4);
        vecs[11] = mkVec(0, 0,  0, 0, 1,  1,  4, 0,  3, 0,  4);
        vecs[12] = mkVec(0, 0,  0, 1, 1,  1,  4, 0,  3, 0,  4);
        vecs[13] = mkVec(0, 0,  0, 0, 0,  0,  4, 1,  4, 0,  5);
        vecs[14] = mkVec(0, 0,  0, 0, 0,  0,  4, 1,  4, 0,  5);
        vecs[15] = mkVec(0, 0,  0, 0, 1,  0,  4, 1,  4, 0,  5);
        vecs[16] = mkVec(0, 0,  0, 1, 0,  1,  5, 0,  4, 0,  5);
        vecs[17] = mkVec(1, 0,  0, 0, 1,  0,  5, 1,  5, 0,  6);
        vecs[18] = mkVec(1, 0,  0, 0, 1,  0,  5, 0,  5, 0,  6);
        vecs[19] = mkVec(1, 0,  0, 0, 1,  0,  5, 0,  5, 0,  6);
        vecs[20] = mkVec(1, 0,  0, 0, 1,  0,  5, 0,  5, 0,  6);
        vecs[21] = mkVec(1, 0,  0, 0, 1,  0,  5, 0,  5, 0,  6);
        vecs[22] = mkVec(0, 0,  0, 0, 1,  0,  5, 0,  5, 0,  6);
        // Redirect without ack enters DISCARD; the stale ack arrives two cycles later
        vecs[23] = mkVec(0, 1,  9, 0, 1,  1,  6, 0,  5, 0,  6);
        vecs[24] = mkVec(0, 0,  0, 0, 1,  1,  6, 0,  5, 0,  9);
        vecs[25] = mkVec(0, 0,  0, 1, 1,  1,  6, 0,  5, 0,  9);
        vecs[26] = mkVec(0, 0,  0, 0, 1,  0,  6, 0,  5, 0,  9);
        vecs[27] = mkVec(0, 0,  0, 1, 1,  1,  9, 0,  5, 0,  9);
        vecs[28] = mkVec(0, 0,  0, 0, 1,  0,  9, 1,  9, 0, 10);
        vecs[29] = mkVec(0, 1,  2, 1, 1,  1, 10, 0,  9, 0, 10);
        vecs[30] = mkVec(0, 0,  0, 0, 1,  0, 10, 0,  9, 0,  2);
        vecs[31] = mkVec(0, 0,  0, 1, 1,  1,  2, 0,  9, 0,  2);
        vecs[32] = mkVec(0, 1, 11, 0, 0,  0,  2, 1,  2, 0,  3);
        vecs[33] = mkVec(0, 0,  0, 0, 1,  0,  2, 0,  2, 0, 11);
        vecs[34] = mkVec(0, 0,  0, 1, 1,  1, 11, 0,  2, 0, 11);
        vecs[35] = mkVec(0, 0,  0, 0, 1,  0, 11, 1, 11, 0, 12);
        vecs[36] = mkVec(0, 0,  0, 1, 1,  1, 12, 0, 11, 0, 12);
        vecs[37] = mkVec(0, 0,  0, 0, 1,  0, 12, 1, 12, 0, 13);
        vecs[38] = mkVec(0, 0,  0, 1, 1,  1, 13, 0, 12, 0, 13);
        vecs[39] = mkVec(0, 0,  0, 0, 0,  0, 13, 1, 13, 1, 13);
        vecs[40] = mkVec(0, 0,  0, 0, 1,  0, 13, 1, 13, 1, 13);
        vecs[41] = mkVec(0, 0,  0, 1, 1,  0, 13, 0, 13, 1, 13);
        vecs[42] = mkVec(0, 1,  0, 0, 1,  0, 13, 0, 13, 1, 13);
        vecs[43] = mkVec(0, 0,  0, 0, 1,  0, 13, 0, 13, 0,  0);
        vecs[44] = mkVec(0, 0,  0, 0, 1,  1,  0, 0, 13, 0,  0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset.instr", outInstr, 32'h0);
        checkOutput("reset.req", 32'(imemReq), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            checkVector(i);
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset in the middle of an outstanding request
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRst.req", 32'(imemReq), 32'h0);
        checkOutput("asyncRst.addr", 32'(imemAddr), 32'h0);
        checkOutput("asyncRst.pc", 32'(pc), 32'h0);
        checkOutput("asyncRst.valid", 32'(outValid), 32'h0);
        checkOutput("asyncRst.outPc", 32'(outPc), 32'h0);
        checkOutput("asyncRst.instr", outInstr, 32'h0);
        checkOutput("asyncRst.halted", 32'(halted), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        stallEn = 1'b0;
        outReady = 1'b1;
        imemAck = 1'b0;
        redirectValid = 1'b0;

        // Free run with a zero-wait memory until the program halts
        expReq = 0;
        expOut = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (imemReq) begin
                checkOutput("run.reqAddr", 32'(imemAddr), 32'(expReq));
                expReq++;
            end
            if (outValid) begin
                checkOutput("run.outPc", 32'(outPc), 32'(expOut));
                checkOutput("run.instr", outInstr, memWord(ADDR_W'(expOut)));
                expOut++;
            end
            imemAck = imemReq;
            if (halted && !outValid) break;
        end
        checkOutput("run.reqCount", 32'(expReq), 32'd14);
        checkOutput("run.outCount", 32'(expOut), 32'd14);
        checkOutput("run.halted", 32'(halted), 32'h1);
        checkOutput("run.pc", 32'(pc), 32'd13);

        lateReqs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imemReq) lateReqs++;
        end
        checkOutput("halt.noReq", 32'(lateReqs), 32'h0);

        // Fetch at the top of the address space wraps pc back to zero
        redirectValid = 1'b1;
        redirectAddr = 9'd511;
        @(negedge clk);
        redirectValid = 1'b0;
        checkOutput("wrap.pcLoad", 32'(pc), 32'd511);
        checkOutput("wrap.unhalt", 32'(halted), 32'h0);
        @(negedge clk);
        checkOutput("wrap.req", 32'(imemReq), 32'h1);
        checkOutput("wrap.addr", 32'(imemAddr), 32'd511);
        imemAck = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        stallEn = 1'b1;
        checkOutput("wrap.pc", 32'(pc), 32'h0);
        checkOutput("wrap.valid", 32'(outValid), 32'h1);
        checkOutput("wrap.outPc", 32'(outPc), 32'd511);
        checkOutput("wrap.instr", outInstr, memWord(9'd511));

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
